ha_bist: RTL and testbench
==========================

# ha_bist

Built-in self-test engine for the half adder `ha`. It drives the four input vectors to a half adder under test and checks the returned carry and sum against expected values. It counts mismatches and reports pass/fail through a start/done handshake. It sits beside an `ha` instance and replaces the open-loop stimulus bench with an in-circuit stimulus-and-check loop.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; must be ≥1.
- `LOOPS`, default 1: number of full passes over the four vectors; must be ≥1.
- `ERR_W`, default 8: width of the error counter.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `dut_a`  out  1  A input to the half adder under test.
- `dut_b`  out  1  B input to the half adder under test.
- `dut_c`  in  1  carry returned by the half adder under test.
- `dut_s`  in  1  sum returned by the half adder under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next start or reset.
- `pass`  out  1  valid while `done` is high; 1 means zero mismatches.
- `err_count`  out  ERR_W  total mismatches; saturates at 2^ERR_W−1.
- `fail_vec`  out  4  sticky per-vector fail flags; bit i = vector {A,B}=i.

## Operation
- States are IDLE, DRIVE, CHECK and DONE.
- Vector order per loop: {A,B} = 00, 01, 10, 11.
- The loop repeats LOOPS times.
- Expected values: C = A & B, S = A ^ B.
- IDLE → DRIVE on `start`=1:
  - clears `err_count`, `fail_vec` and `pass`;
  - sets vector index 0 and loop index 0.
- DRIVE: `dut_a`/`dut_b` present the current vector; the state lasts exactly SETTLE cycles, then goes to CHECK.
- CHECK lasts one cycle.
  - At its closing edge, `dut_c`/`dut_s` are compared to the expected values.
  - On mismatch (either bit differs), `err_count` increments (saturating) and `fail_vec[idx]` is set.
  - Next state:
    - if not the last vector of the last loop, advance the index (wrapping 3→0 increments the loop index) and go to DRIVE;
    - otherwise go to DONE.
- DONE:
  - `done`=1, `busy`=0, `pass` = (`err_count`==0);
  - results held; `dut_a`/`dut_b` return to 0;
  - `start`=1 clears results and enters DRIVE at vector 0, as from IDLE.
- `start` during DRIVE or CHECK is ignored.

## Timing
- Reset values: `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0000, state IDLE.
- Reset asserted mid-run aborts immediately to these values. There is no resume.
- `busy` rises in the cycle after the `start` edge and stays high for exactly LOOPS·4·(SETTLE+1) cycles.
  - Defaults: 12 cycles.
- `done` rises on the same edge that `busy` falls.
- All outputs are registered; no combinational path runs from `dut_c`/`dut_s` to any output.
- The DUT path is combinational and must settle within SETTLE−1 cycles plus one clock period.
- Counter width rules:
  - the settle counter is sized to clog2(SETTLE+1);
  - the loop counter is sized to clog2(LOOPS+1);
  - increments at 2^ERR_W−1 hold the value (no wrap).

## Structure
- Shared package `ha_pkg` holds:
  - the state enum (IDLE, DRIVE, CHECK, DONE);
  - the constant NUM_VEC = 4;
  - functions returning expected carry and sum for {A,B}.
- No sub-module is required inside `ha_bist`; the compare logic uses the package functions.
- The top-level bench instantiates the existing `ha` as the unit under test, wired to `dut_a`/`dut_b`/`dut_c`/`dut_s`.

## Test plan
- Good `ha` connected, defaults, `rst_n` released, `start` pulsed one cycle → `busy` high 12 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_vec`=0000.
- `dut_c` forced to 0 → only vector 11 fails: `err_count`=1, `fail_vec`=1000, `pass`=0.
- `dut_c` and `dut_s` swapped → vectors 01, 10 and 11 fail: `fail_vec`=1110, `err_count`=3.
- LOOPS=100, ERR_W=4, `dut_s` stuck at 1 → 200 raw mismatches (vectors 00 and 11); `err_count` saturates at 15, `fail_vec`=1001.
- `rst_n` pulsed low during DRIVE of vector 2 → all outputs return to reset values asynchronously and state is IDLE. In a separate run, `start` pulses while `busy`=1 have no effect and total busy length stays 12.
- In DONE after a failing run, `start` pulsed with a good `ha` → results clear the next cycle and the run repeats, ending with `pass`=1 and `err_count`=0.

Source files
------------

// File: rtl/ha_pkg.sv
// ha_pkg: shared state encoding and golden half-adder model for ha_bist.
package ha_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam int NUM_VEC = 4;
  function automatic logic exp_c(input logic [1:0] v);
    return v[1] & v[0];
  endfunction
  function automatic logic exp_s(input logic [1:0] v);
    return v[1] ^ v[0];
  endfunction
endpackage

// File: rtl/ha.sv
// ha: combinational half adder, the unit exercised by ha_bist.
module ha (
  input  logic a,
  input  logic b,
  output logic c,
  output logic s
);
  assign c = a & b;
  assign s = a ^ b;
endmodule

// File: rtl/ha_bist.sv
// ha_bist: drives all four half-adder vectors LOOPS times and tallies mismatches.
module ha_bist
  import ha_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_c,
  input  logic             dut_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOOPS + 1);
  state_t        st;
  logic [1:0]    idx;
  logic [LW-1:0] loop;
  logic [SW-1:0] cnt;
  logic          mis, last;
  assign mis  = (dut_c != exp_c(idx)) || (dut_s != exp_s(idx));
  assign last = (idx == 2'(NUM_VEC - 1)) && (loop == LW'(LOOPS - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= IDLE;
      idx       <= '0;
      loop      <= '0;
      cnt       <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (st)
        IDLE, DONE:
          if (start) begin
            st           <= DRIVE;
            idx          <= '0;
            loop         <= '0;
            cnt          <= '0;
            {dut_a, dut_b} <= 2'b00;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_vec     <= '0;
          end
        DRIVE: begin
          cnt <= cnt + 1'b1;
          if (cnt == SW'(SETTLE - 1)) begin
            st  <= CHECK;
            cnt <= '0;
          end
        end
        CHECK: begin
          if (mis) begin
            err_count     <= (err_count == '1) ? err_count : err_count + 1'b1;
            fail_vec[idx] <= 1'b1;
          end
          if (last) begin
            st             <= DONE;
            {dut_a, dut_b} <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b1;
            pass           <= (err_count == '0) && !mis;
          end else begin
            st             <= DRIVE;
            idx            <= idx + 2'd1;
            loop           <= (idx == 2'(NUM_VEC - 1)) ? loop + 1'b1 : loop;
            {dut_a, dut_b} <= idx + 2'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ha_bist.sv
// tb_ha_bist: directed checks of ha_bist against good and faulty half adders.
module tb_ha_bist;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  int   mode = 0;
  logic dut_a, dut_b, dut_c, dut_s, busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;
  logic hc, hs;
  logic a2, b2, hc2, hs2, busy2, done2, pass2;
  logic [3:0] err2, fail2;
  int total = 0, passes = 0, fails = 0;
  int len;
  logic seq_ok;
  always #5 clk = ~clk;
  ha u_ha (.a(dut_a), .b(dut_b), .c(hc), .s(hs));
  assign dut_c = (mode == 1) ? 1'b0 : (mode == 2) ? hs : hc;
  assign dut_s = (mode == 2) ? hc : hs;
  ha_bist u_dut (.clk(clk), .rst_n(rst_n), .start(start), .dut_a(dut_a), .dut_b(dut_b),
    .dut_c(dut_c), .dut_s(dut_s), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec));
  ha u_ha2 (.a(a2), .b(b2), .c(hc2), .s(hs2));
  ha_bist #(.SETTLE(2), .LOOPS(100), .ERR_W(4)) u_dut2 (.clk(clk), .rst_n(rst_n),
    .start(start2), .dut_a(a2), .dut_b(b2), .dut_c(hc2), .dut_s(1'b1), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ab"}, {dut_a, dut_b}, 0);
    chk({tag, "_flags"}, {busy, done, pass}, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fvec"}, fail_vec, 0);
  endtask
  // pulse start, then count busy cycles while checking the vector sequence
  task automatic run(input bit poke, output int n, output logic ok);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    ok = 1;
    while (busy && n < 200) begin
      if ({dut_a, dut_b} != 2'((n / 3) % 4)) ok = 0;
      n++;
      start = poke && (n == 2 || n == 5 || n == 8);
      @(negedge clk);
    end
    start = 0;
  endtask
  initial begin
    #12;
    chk_reset("reset");
    rst_n = 1;
    @(negedge clk);
    chk_reset("idle");
    run(0, len, seq_ok);
    chk("good_busy_len", len, 12);
    chk("good_seq", seq_ok, 1);
    chk("good_done", {busy, done, pass}, 3'b011);
    chk("good_err", err_count, 0);
    chk("good_fvec", fail_vec, 4'b0000);
    chk("good_ab_idle", {dut_a, dut_b}, 0);
    mode = 1;
    run(0, len, seq_ok);
    chk("c0_done", {done, pass}, 2'b10);
    chk("c0_err", err_count, 1);
    chk("c0_fvec", fail_vec, 4'b1000);
    repeat (3) @(negedge clk);
    chk("c0_hold", {done, err_count}, {1'b1, 8'd1});
    mode = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("restart_clear", {busy, done, pass, err_count, fail_vec}, {3'b100, 8'd0, 4'd0});
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("restart_done", {done, pass, err_count}, {2'b11, 8'd0});
    mode = 2;
    run(0, len, seq_ok);
    chk("swap_err", err_count, 3);
    chk("swap_fvec", fail_vec, 4'b1110);
    chk("swap_pass", pass, 0);
    mode = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int i = 0; i < 20 && !(dut_a && !dut_b); i++) @(negedge clk);
    chk("mid_vec2", {busy, dut_a, dut_b}, 3'b110);
    #2 rst_n = 0;
    #1 chk_reset("async_rst");
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
    chk_reset("post_rst_idle");
    run(1, len, seq_ok);
    chk("ignore_busy_len", len, 12);
    chk("ignore_seq", seq_ok, 1);
    chk("ignore_pass", {done, pass}, 2'b11);
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    len = 0;
    while (busy2 && len < 5000) begin
      len++;
      @(negedge clk);
    end
    chk("sat_busy_len", len, 1200);
    chk("sat_err", err2, 15);
    chk("sat_fvec", fail2, 4'b1001);
    chk("sat_done", {done2, pass2}, 2'b10);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
